// File: rtl/sweep_pkg.sv
// Shared definitions for truth-table sweepers.
// Contents:
//   sweep_state_e  sweep controller state encoding (IDLE, RUN, DONE)
//   F_YXZ_TT       truth table of F = y | (~x & z), bit i = F(code i), x = MSB
//   NUM_CODES      number of codes swept for the default 3-input function
//   num_codes()    number of codes for an arbitrary input count
package sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sweep_state_e;

  localparam logic [7:0] F_YXZ_TT     = 8'hCE;
  localparam int         N_IN_DEFAULT = 3;
  localparam int         NUM_CODES    = 2 ** N_IN_DEFAULT;

  function automatic int num_codes(input int n_in);
    return 32'sd1 << n_in;
  endfunction

endpackage

// File: rtl/step_timer.sv
// Step timer: counts 0..STEP_CYCLES-1 while enabled and flags the last cycle
// of each step so a controller knows when to sample and advance.
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset, clears the count
//   clear  synchronous clear, has priority over en
//   en     advance the count by one (wrapping to 0 after the last cycle)
//   last   high while the count equals STEP_CYCLES-1
module step_timer #(
  parameter int STEP_CYCLES = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic last
);

  // A one-cycle step still needs a 1-bit counter; it simply never leaves 0.
  localparam int            W        = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [W-1:0]  STEP_MAX = W'(STEP_CYCLES - 1);

  logic [W-1:0] step_q;
  logic [W-1:0] step_d;

  assign last = (step_q == STEP_MAX);

  // Next count: clear wins, otherwise wrap after the last cycle of a step.
  always_comb begin
    step_d = step_q;
    if (clear) begin
      step_d = {W{1'b0}};
    end else if (en) begin
      if (last) begin
        step_d = {W{1'b0}};
      end else begin
        step_d = step_q + W'(1);
      end
    end else begin
      step_d = step_q;
    end
  end

  // Step count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q <= {W{1'b0}};
    end else begin
      step_q <= step_d;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives every input code 0..2^N_IN-1 onto vec, holds
// each for STEP_CYCLES clocks, and on the last cycle of each step checks the
// SOP and POS implementations against each other and against EXPECTED.
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   start         begin a sweep (ignored while busy)
//   f_sop, f_pos  combinational function outputs driven from vec
//   vec           current input code {x,y,z}
//   busy, done    sweep in progress / sweep complete (done is a level)
//   pass          1 iff the finished sweep had no failing code (valid with done)
//   mismatch_cnt  number of failing codes in the current/last sweep
//   fail_valid    at least one failing code recorded
//   fail_idx      first failing code (valid with fail_valid)
module truth_table_sweeper
  import sweep_pkg::*;
#(
  parameter int                   N_IN        = 3,
  parameter int                   STEP_CYCLES = 10,
  parameter logic [(2**N_IN)-1:0] EXPECTED    = F_YXZ_TT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            f_sop,
  input  logic            f_pos,
  output logic [N_IN-1:0] vec,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   mismatch_cnt,
  output logic            fail_valid,
  output logic [N_IN-1:0] fail_idx
);

  localparam logic [N_IN-1:0] LAST_CODE = N_IN'(num_codes(N_IN) - 1);
  localparam logic [N_IN:0]   CNT_ONE   = {{N_IN{1'b0}}, 1'b1};

  sweep_state_e    state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   cnt_q, cnt_d;
  logic            fail_valid_q, fail_valid_d;
  logic [N_IN-1:0] fail_idx_q, fail_idx_d;

  logic            timer_clear_s;
  logic            timer_en_s;
  logic            step_last_s;
  logic            code_fail_s;
  logic [N_IN:0]   cnt_inc_s;

  step_timer #(
    .STEP_CYCLES (STEP_CYCLES)
  ) u_step_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_clear_s),
    .en    (timer_en_s),
    .last  (step_last_s)
  );

  // A code fails when the two forms disagree or differ from the table.
  assign code_fail_s = (f_sop != f_pos) || (f_sop != EXPECTED[vec_q]);
  assign cnt_inc_s   = cnt_q + (code_fail_s ? CNT_ONE : {(N_IN+1){1'b0}});

  // Next-state and next-output logic of the sweep controller.
  always_comb begin
    state_d       = state_q;
    vec_d         = vec_q;
    busy_d        = busy_q;
    done_d        = done_q;
    pass_d        = pass_q;
    cnt_d         = cnt_q;
    fail_valid_d  = fail_valid_q;
    fail_idx_d    = fail_idx_q;
    timer_clear_s = 1'b0;
    timer_en_s    = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d       = RUN;
          vec_d         = {N_IN{1'b0}};
          busy_d        = 1'b1;
          done_d        = 1'b0;
          pass_d        = 1'b0;
          cnt_d         = {(N_IN+1){1'b0}};
          fail_valid_d  = 1'b0;
          fail_idx_d    = {N_IN{1'b0}};
          timer_clear_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      RUN: begin
        timer_en_s = 1'b1;
        if (step_last_s) begin
          cnt_d = cnt_inc_s;
          if (code_fail_s && !fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_idx_d   = vec_q;
          end else begin
            fail_valid_d = fail_valid_q;
          end
          // The last code ends the sweep; vec stays on it rather than wrapping.
          if (vec_q == LAST_CODE) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (cnt_inc_s == {(N_IN+1){1'b0}});
          end else begin
            vec_d = vec_q + N_IN'(1);
          end
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        pass_d  = 1'b0;
      end
    endcase
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      vec_q        <= {N_IN{1'b0}};
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      cnt_q        <= {(N_IN+1){1'b0}};
      fail_valid_q <= 1'b0;
      fail_idx_q   <= {N_IN{1'b0}};
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      cnt_q        <= cnt_d;
      fail_valid_q <= fail_valid_d;
      fail_idx_q   <= fail_idx_d;
    end
  end

  assign vec          = vec_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign mismatch_cnt = cnt_q;
  assign fail_valid   = fail_valid_q;
  assign fail_idx     = fail_idx_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

  localparam int STEP    = 10;
  localparam int CODES   = 8;
  localparam int RUN_LEN = CODES * STEP;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       f_sop, f_pos;
  logic [2:0] vec;
  logic       busy, done, pass, fail_valid;
  logic [3:0] mcnt;
  logic [2:0] fidx;

  logic       start2 = 1'b0;
  logic       f2;
  logic [1:0] vec2;
  logic       busy2, done2, pass2, fail_valid2;
  logic [2:0] mcnt2;
  logic [1:0] fidx2;

  int mode = 0;

  typedef struct {
    logic pass;
    int   cnt;
    logic fv;
    int   fidx;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   mon_el;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   start_edge = 0;
  bit   run_active = 1'b0;
  logic done_prev = 1'b0;

  truth_table_sweeper #(.N_IN(3), .STEP_CYCLES(STEP), .EXPECTED(8'hCE)) u_dut (
    .clk(clk), .rst(rst), .start(start), .f_sop(f_sop), .f_pos(f_pos),
    .vec(vec), .busy(busy), .done(done), .pass(pass), .mismatch_cnt(mcnt),
    .fail_valid(fail_valid), .fail_idx(fidx)
  );

  truth_table_sweeper #(.N_IN(2), .STEP_CYCLES(1), .EXPECTED(4'h6)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .f_sop(f2), .f_pos(f2),
    .vec(vec2), .busy(busy2), .done(done2), .pass(pass2), .mismatch_cnt(mcnt2),
    .fail_valid(fail_valid2), .fail_idx(fidx2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Function under test, written independently in SOP and POS form, with faults.
  always_comb begin
    logic sop_m, pos_m;
    sop_m = vec[1] | (~vec[2] & vec[0]);
    pos_m = (vec[1] | vec[0]) & (vec[1] | ~vec[2]);
    f_sop = sop_m;
    f_pos = pos_m;
    case (mode)
      1: f_pos = (vec == 3'd3) ? 1'b0 : pos_m;
      2: begin f_sop = 1'b1; f_pos = 1'b1; end
      default: begin f_sop = sop_m; f_pos = pos_m; end
    endcase
  end

  assign f2 = vec2[1] ^ vec2[0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Monitor: checks the code sequence during a run and pops the scoreboard on done.
  always @(negedge clk) begin
    mon_el = cyc - start_edge;
    if (done === 1'b1 && done_prev !== 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("done_latency", mon_el, RUN_LEN);
        chk("pass", 32'(pass), 32'(mon_e.pass));
        chk("mismatch_cnt", 32'(mcnt), mon_e.cnt);
        chk("fail_valid", 32'(fail_valid), 32'(mon_e.fv));
        chk("fail_idx", 32'(fidx), mon_e.fidx);
        chk("vec_final", 32'(vec), 32'd7);
        chk("busy_at_done", 32'(busy), 32'd0);
      end
      run_active = 1'b0;
    end else if (run_active && mon_el >= 0) begin
      if (mon_el < RUN_LEN) begin
        chk("vec_step", 32'(vec), mon_el / STEP);
        chk("busy_run", 32'(busy), 32'd1);
        chk("pass_run", 32'(pass), 32'd0);
      end else if (mon_el > RUN_LEN) begin
        chk("done_timeout", 32'(done), 32'd1);
        run_active = 1'b0;
      end
    end
    done_prev = done;
  end

  task automatic launch(input int m, input bit expect_done, input exp_t e);
    @(negedge clk);
    mode       = m;
    start      = 1'b1;
    start_edge = cyc + 1;
    run_active = 1'b1;
    if (expect_done) sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < RUN_LEN + 20; i++) begin
      if (!run_active) break;
      @(negedge clk);
    end
    if (run_active) begin
      chk("wait_idle_timeout", 32'(run_active), 32'd0);
      run_active = 1'b0;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_vec"}, 32'(vec), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
    chk({tag, "_cnt"}, 32'(mcnt), 32'd0);
    chk({tag, "_fv"}, 32'(fail_valid), 32'd0);
    chk({tag, "_fidx"}, 32'(fidx), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e_ok, e_pos3, e_one;
    e_ok   = '{pass: 1'b1, cnt: 0, fv: 1'b0, fidx: 0};
    e_pos3 = '{pass: 1'b0, cnt: 1, fv: 1'b1, fidx: 3};
    e_one  = '{pass: 1'b0, cnt: 3, fv: 1'b1, fidx: 0};

    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;

    // Clean sweep; done then holds with vec parked on the last code.
    launch(0, 1'b1, e_ok);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("done_held", 32'(done), 32'd1);
    chk("vec_held", 32'(vec), 32'd7);

    // Restart from DONE with f_pos broken at code 3.
    launch(1, 1'b1, e_pos3);
    chk("restart_done_low", 32'(done), 32'd0);
    chk("restart_pass_low", 32'(pass), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    wait_idle();

    // Constant-1 outputs; counters from the previous sweep must clear; a
    // start at cycle 30 of the run is ignored.
    launch(2, 1'b1, e_one);
    chk("restart_cnt_clr", 32'(mcnt), 32'd0);
    chk("restart_fv_clr", 32'(fail_valid), 32'd0);
    chk("restart_fidx_clr", 32'(fidx), 32'd0);
    repeat (29) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Reset mid-run with a failure already recorded.
    launch(1, 1'b0, e_pos3);
    repeat (44) @(negedge clk);
    chk("pre_rst_fv", 32'(fail_valid), 32'd1);
    chk("pre_rst_cnt", 32'(mcnt), 32'd1);
    rst        = 1'b1;
    run_active = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 32'(busy), 32'd0);

    launch(0, 1'b1, e_ok);
    wait_idle();

    // Two-input XOR sweeper with one-cycle steps.
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk("x2_vec", 32'(vec2), j);
      chk("x2_busy", 32'(busy2), 32'd1);
      chk("x2_done_low", 32'(done2), 32'd0);
      @(negedge clk);
    end
    chk("x2_done", 32'(done2), 32'd1);
    chk("x2_pass", 32'(pass2), 32'd1);
    chk("x2_cnt", 32'(mcnt2), 32'd0);
    chk("x2_vec_final", 32'(vec2), 32'd3);
    chk("x2_busy_end", 32'(busy2), 32'd0);

    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
